// File: rtl/aer_rx_pkg.sv
// Shared types and event-word layout for the AER receiver.
// Word layout: {ts, pol_on, pol_off, addry, addrx}.
package aer_rx_pkg;

  localparam int ADDR_W    = 4;
  localparam int EVT_X_LSB = 0;
  localparam int EVT_Y_LSB = ADDR_W;
  localparam int EVT_OFF   = 2 * ADDR_W;
  localparam int EVT_ON    = 2 * ADDR_W + 1;
  localparam int EVT_PAY_W = 2 * ADDR_W + 2;
  localparam int EVT_TS_LSB = EVT_PAY_W;

  typedef enum logic [2:0] {
    ST_ARM,
    ST_IDLE,
    ST_SETTLE,
    ST_PUSH,
    ST_WAIT_REL
  } state_e;

endpackage

// File: rtl/aer_evt_fifo.sv
// Synchronous show-ahead FIFO; head word is always on rdata.
// Push is refused when full, pop is ignored when empty.
module aer_evt_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    level_d  = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/aer_event_capture.sv
// AER 4-phase receiver: sync, settle, timestamp, ack, and queue events.
// A full FIFO holds ACK low, stalling the arbiters instead of dropping.
module aer_event_capture
  import aer_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int TS_W       = 16,
  parameter int SETTLE     = 2
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          REQON,
  input  logic                          REQOFF,
  input  logic [ADDR_W-1:0]             ADDRX,
  input  logic [ADDR_W-1:0]             ADDRY,
  output logic                          ACK,
  output logic [TS_W+EVT_PAY_W-1:0]     EVT_DATA,
  output logic                          EVT_VALID,
  input  logic                          EVT_READY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

  localparam int CNT_W = $clog2(SETTLE + 1);

  logic                 on_s1_q, on_s2_q, off_s1_q, off_s2_q;
  logic                 req_s, req_s1;
  logic [TS_W-1:0]      ts_q, ts_d;
  logic [TS_W-1:0]      ts_lat_q, ts_lat_d;
  logic [EVT_PAY_W-1:0] pay_q, pay_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  state_e               state_q, state_d;
  logic                 ack_q, ack_d;
  logic                 arm_ok_q;
  logic                 push, fifo_full, fifo_empty;

  assign req_s  = on_s2_q | off_s2_q;
  assign req_s1 = on_s1_q | off_s1_q;
  assign ts_d   = ts_q + TS_W'(1);

  // arm_ok_q keeps ARM from leaving before the synchronizers hold real samples
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ack_d    = ack_q;
    ts_lat_d = ts_lat_q;
    pay_d    = pay_q;
    push     = 1'b0;
    unique case (state_q)
      ST_ARM: begin
        if (arm_ok_q && !req_s && !req_s1) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (req_s) begin
          ts_lat_d = ts_q;
          cnt_d    = CNT_W'(SETTLE);
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          pay_d   = {on_s2_q, off_s2_q, ADDRY, ADDRX};
          state_d = ST_PUSH;
        end
      end
      ST_PUSH: begin
        if (!fifo_full) begin
          push    = 1'b1;
          ack_d   = 1'b1;
          state_d = ST_WAIT_REL;
        end
      end
      ST_WAIT_REL: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_ARM;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      on_s1_q  <= 1'b0;
      on_s2_q  <= 1'b0;
      off_s1_q <= 1'b0;
      off_s2_q <= 1'b0;
      ts_q     <= '0;
      ts_lat_q <= '0;
      pay_q    <= '0;
      cnt_q    <= '0;
      state_q  <= ST_ARM;
      ack_q    <= 1'b0;
      arm_ok_q <= 1'b0;
    end else begin
      on_s1_q  <= REQON;
      on_s2_q  <= on_s1_q;
      off_s1_q <= REQOFF;
      off_s2_q <= off_s1_q;
      ts_q     <= ts_d;
      ts_lat_q <= ts_lat_d;
      pay_q    <= pay_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      ack_q    <= ack_d;
      arm_ok_q <= 1'b1;
    end
  end

  assign ACK       = ack_q;
  assign EVT_VALID = !fifo_empty;

  aer_evt_fifo #(
    .WIDTH (TS_W + EVT_PAY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (push),
    .wdata ({ts_lat_q, pay_q}),
    .pop   (EVT_READY),
    .rdata (EVT_DATA),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (FIFO_LEVEL)
  );

endmodule

// File: tb/tb_aer_event_capture.sv
// Directed bench for aer_event_capture with a 4-bit timestamp.
// Scoreboard queue holds expected words; cyc models the timestamp counter.
module tb_aer_event_capture;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        REQON = 1'b0;
  logic        REQOFF = 1'b0;
  logic [3:0]  ADDRX = '0;
  logic [3:0]  ADDRY = '0;
  logic        ACK;
  logic [13:0] EVT_DATA;
  logic        EVT_VALID;
  logic        EVT_READY = 1'b0;
  logic [3:0]  FIFO_LEVEL;

  int n_vec = 0;
  int n_err = 0;
  int cyc;
  logic [14:0] exp_q [$];

  aer_event_capture #(
    .FIFO_DEPTH (8),
    .TS_W       (4),
    .SETTLE     (2)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .REQON      (REQON),
    .REQOFF     (REQOFF),
    .ADDRX      (ADDRX),
    .ADDRY      (ADDRY),
    .ACK        (ACK),
    .EVT_DATA   (EVT_DATA),
    .EVT_VALID  (EVT_VALID),
    .EVT_READY  (EVT_READY),
    .FIFO_LEVEL (FIFO_LEVEL)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ts is the counter value at IDLE->SETTLE, four edges before ACK rises
  task automatic send(input logic on, input logic off,
                      input logic [3:0] x, input logic [3:0] y,
                      output int rise, output int fall);
    logic [3:0] ts;
    @(negedge CLK);
    REQON = on; REQOFF = off; ADDRX = x; ADDRY = y;
    rise = 0;
    while (!ACK && rise < 100) begin
      @(posedge CLK); #1; rise++;
    end
    chk("ack_rise", ACK, 1);
    ts = 4'(cyc - 4);
    exp_q.push_back({1'b1, ts, on, off, y, x});
    #10;
    REQON = 1'b0; REQOFF = 1'b0;
    fall = 0;
    while (ACK && fall < 100) begin
      @(posedge CLK); #1; fall++;
    end
    chk("ack_fall", ACK, 0);
  endtask

  task automatic drain();
    logic [14:0] e;
    int n = 0;
    int want = exp_q.size();
    @(negedge CLK);
    while (EVT_VALID && n < 20) begin
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e[14]) chk("head", EVT_DATA, e[13:0]);
        else chk("head_pay", EVT_DATA[9:0], e[9:0]);
      end
      n++;
      EVT_READY = 1'b1;
      @(negedge CLK);
    end
    EVT_READY = 1'b0;
    chk("drain_cnt", n, want);
    chk("drain_lvl", FIFO_LEVEL, 0);
  endtask

  int r, f, n;
  logic [14:0] e;
  logic [3:0] ts0;

  initial begin
    #22 RST_N = 1'b1;
    @(negedge CLK);
    chk("rst_ack", ACK, 0);
    chk("rst_valid", EVT_VALID, 0);
    chk("rst_level", FIFO_LEVEL, 0);
    repeat (4) @(negedge CLK);

    // single ON event
    send(1'b1, 1'b0, 4'd6, 4'd0, r, f);
    chk("on_lat", r, 6);
    chk("on_fall_lat", f, 3);
    chk("on_level", FIFO_LEVEL, 1);
    chk("on_valid", EVT_VALID, 1);
    chk("on_pay", EVT_DATA[9:0], 10'b10_0000_0110);
    drain();

    // simultaneous ON+OFF
    send(1'b1, 1'b1, 4'd5, 4'd11, r, f);
    chk("both_level", FIFO_LEVEL, 1);
    chk("both_pay", EVT_DATA[9:0], 10'b11_1011_0101);
    drain();

    // timestamp wrap: first event latched at 15, next wraps
    n = 0;
    while ((cyc & 15) != 13 && n < 40) begin
      @(negedge CLK); n++;
    end
    REQON = 1'b1; ADDRX = 4'd1; ADDRY = 4'd2;
    r = 0;
    while (!ACK && r < 100) begin
      @(posedge CLK); #1; r++;
    end
    chk("wrap_ack", ACK, 1);
    ts0 = EVT_DATA[13:10];
    chk("wrap_ts15", ts0, 15);
    exp_q.push_back({1'b1, 4'd15, 2'b10, 4'd2, 4'd1});
    #10 REQON = 1'b0;
    n = 0;
    while (ACK && n < 100) begin
      @(posedge CLK); #1; n++;
    end
    for (int i = 0; i < 3; i++)
      send(1'b0, 1'b1, 4'(i), 4'(9 - i), r, f);
    chk("wrap_level", FIFO_LEVEL, 4);
    drain();

    // backpressure: 8 accepted, 9th and 10th stall until a pop
    for (int i = 0; i < 8; i++)
      send(1'b1, 1'b0, 4'(i), 4'(15 - i), r, f);
    chk("bp_full", FIFO_LEVEL, 8);
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      REQON = 1'b1; ADDRX = 4'(12 + k); ADDRY = 4'(3 + k);
      repeat (20) @(negedge CLK);
      chk("bp_stall_ack", ACK, 0);
      chk("bp_stall_lvl", FIFO_LEVEL, 8);
      e = exp_q.pop_front();
      chk("bp_pop_head", EVT_DATA, e[13:0]);
      EVT_READY = 1'b1;
      @(posedge CLK); #1;
      EVT_READY = 1'b0;
      n = 0;
      while (!ACK && n < 20) begin
        @(posedge CLK); #1; n++;
      end
      chk("bp_ack_lat", n, 1);
      exp_q.push_back({1'b0, 4'd0, 2'b10, 4'(3 + k), 4'(12 + k)});
      #10 REQON = 1'b0;
      n = 0;
      while (ACK && n < 100) begin
        @(posedge CLK); #1; n++;
      end
      chk("bp_rel", ACK, 0);
    end
    drain();

    // concurrent push and pop at level 3
    for (int i = 0; i < 3; i++)
      send(1'b1, 1'b0, 4'(7 + i), 4'(i), r, f);
    chk("pp_lvl3", FIFO_LEVEL, 3);
    @(negedge CLK);
    REQON = 1'b1; ADDRX = 4'd14; ADDRY = 4'd13;
    repeat (5) begin
      @(posedge CLK); #1;
    end
    e = exp_q.pop_front();
    chk("pp_head", EVT_DATA, e[13:0]);
    EVT_READY = 1'b1;
    @(posedge CLK); #1;
    EVT_READY = 1'b0;
    chk("pp_ack", ACK, 1);
    chk("pp_level", FIFO_LEVEL, 3);
    exp_q.push_back({1'b1, 4'(cyc - 4), 2'b10, 4'd13, 4'd14});
    #10 REQON = 1'b0;
    n = 0;
    while (ACK && n < 100) begin
      @(posedge CLK); #1; n++;
    end
    drain();

    // reset during WAIT_REL with REQ still high
    @(negedge CLK);
    REQON = 1'b1; ADDRX = 4'd3; ADDRY = 4'd9;
    n = 0;
    while (!ACK && n < 100) begin
      @(posedge CLK); #1; n++;
    end
    chk("rm_ack_pre", ACK, 1);
    chk("rm_lvl_pre", FIFO_LEVEL, 1);
    #2 RST_N = 1'b0;
    #1;
    chk("rm_ack", ACK, 0);
    chk("rm_level", FIFO_LEVEL, 0);
    chk("rm_valid", EVT_VALID, 0);
    exp_q.delete();
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (20) @(negedge CLK);
    chk("rm_arm_ack", ACK, 0);
    chk("rm_arm_lvl", FIFO_LEVEL, 0);
    REQON = 1'b0;
    repeat (5) @(negedge CLK);
    chk("rm_low_lvl", FIFO_LEVEL, 0);
    send(1'b1, 1'b0, 4'd10, 4'd4, r, f);
    chk("rm_new_lat", r, 6);
    chk("rm_new_lvl", FIFO_LEVEL, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
